lcd_bus_controller: RTL and testbench
=====================================

LCD_BUS_CONTROLLER -- requirements
Module: lcd_bus_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter T_AS, default 6: clk cycles from RS/RW/dir valid to E rise (address setup).
REQ-003 Parameter T_PW, default 45: clk cycles E is held high.
REQ-004 Parameter T_H, default 2: clk cycles after E fall with RS/RW/dir/wr_data held (hold).
REQ-005 Parameter T_GAP, default 50: idle clk cycles after hold before the next access.
REQ-006 Parameter POLL_EN, default 1: 1 enables a busy-flag poll after every write.
REQ-007 Parameter POLL_MAX, default 255: maximum busy polls before timeout.
REQ-008 Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  access request
- req_ready  out  1  request accepted when both high
- req_rs  in  1  0 = instruction, 1 = data register
- req_rw  in  1  0 = write, 1 = read
- req_data  in  8  write data
- resp_valid  out  1  one-cycle pulse, access complete
- resp_data  out  8  read data (0 for writes)
- resp_err  out  1  busy-poll timeout, valid with resp_valid
- lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control pins
- dir  out  1  to data router: 1 = bus released/capture, 0 = drive
- wr_data  out  8  to data router input
- rd_data  in  8  from data router registered output

Function
REQ-009 The block SHALL use states IDLE, SETUP, PULSE, HOLD and GAP, each with a shared down-counter loaded on entry.
REQ-010 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-011 On handshake, req_rs/req_rw/req_data SHALL be latched and the block SHALL enter SETUP.
REQ-012 lcd_rs, lcd_rw, dir (= latched rw) and wr_data SHALL be stable from SETUP entry through the last HOLD cycle.
REQ-013 SETUP SHALL last T_AS cycles, PULSE T_PW cycles (lcd_e = 1, registered) and HOLD T_H cycles, then GAP T_GAP cycles.
REQ-014 For reads, rd_data SHALL be captured on the final PULSE cycle.
- Rationale: the router adds one register stage.
REQ-015 With POLL_EN = 1, a completed write SHALL be followed, after GAP, by automatic reads with RS = 0 and RW = 1, repeated until captured bit 7 = 0.
REQ-016 resp_valid SHALL pulse for exactly one cycle at the end of GAP of the final access of a request, i.e. after the last poll when polling.
REQ-017 If POLL_MAX polls all return bit 7 = 1, the block SHALL pulse resp_valid with resp_err = 1 and return to IDLE.
REQ-018 In IDLE, dir SHALL be 0, lcd_e 0, lcd_rw 0, and lcd_rs SHALL hold its last value.
REQ-019 dir SHALL change only while lcd_e = 0 and at least T_H cycles after E fall.
REQ-020 T_AS, T_PW, T_H and T_GAP values of 0 SHALL be treated as 1.
REQ-021 req_valid asserted while busy SHALL be ignored and not queued.

Reset
REQ-022 Asserting rst_n low SHALL immediately and asynchronously force IDLE, with lcd_e, lcd_rs, lcd_rw, dir, resp_valid, resp_err, resp_data and wr_data at 0.
REQ-023 Reset asserted mid-PULSE SHALL drop lcd_e in the same instant, and no resp_valid SHALL follow for the aborted request.
REQ-024 req_ready SHALL be 1 on the first clk edge after rst_n is released.

Structure
REQ-025 The state encoding and default timing constants SHALL live in a shared package, lcd_pkg.
REQ-026 The block SHALL instantiate no sub-modules.
- It connects externally to the data router through dir, wr_data and rd_data.
- An optional wrapper, lcd_if_top, is the natural place to join the two.

Verification
REQ-027 Write rs=1, data=0x41, POLL_EN=0 -> lcd_e high for exactly 45 cycles, starting 6 cycles after accept; wr_data=0x41 and dir=0 throughout; resp_valid at accept+6+45+2+50.
REQ-028 Read rs=1, model drives 0x5A -> dir=1 from SETUP to HOLD end; resp_data=0x5A; resp_err=0.
REQ-029 Write with POLL_EN=1, model busy for 3 polls -> 4 E pulses after the write pulse, one resp_valid with resp_err=0.
REQ-030 Model busy forever, POLL_MAX=4 -> exactly 4 polls, then resp_valid with resp_err=1, then IDLE.
REQ-031 rst_n low at cycle 20 of PULSE -> lcd_e=0 immediately, no resp_valid, req_ready=1 one edge after release.
REQ-032 req_valid held high for back-to-back writes -> second accept no earlier than GAP end; lcd_e never high during dir transitions.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encoding, default timing constants and counter-load helper
// for the character-LCD bus controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } lcd_state_e;

    localparam int unsigned LCD_T_AS_DEF     = 6;
    localparam int unsigned LCD_T_PW_DEF     = 45;
    localparam int unsigned LCD_T_H_DEF      = 2;
    localparam int unsigned LCD_T_GAP_DEF    = 50;
    localparam int unsigned LCD_POLL_EN_DEF  = 1;
    localparam int unsigned LCD_POLL_MAX_DEF = 255;

    localparam int unsigned LCD_CNT_W = 16;

    // Down-counter load for a phase lasting t cycles; zero is treated as one.
    function automatic logic [LCD_CNT_W-1:0] lcd_load(input int unsigned t);
        if (t <= 1) begin
            return '0;
        end
        return LCD_CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/lcd_bus_controller.sv
// HD44780-style bus sequencer: address setup, E pulse, hold and inter-access
// gap, with optional busy-flag polling after every write.
module lcd_bus_controller
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS     = LCD_T_AS_DEF,
    parameter int unsigned T_PW     = LCD_T_PW_DEF,
    parameter int unsigned T_H      = LCD_T_H_DEF,
    parameter int unsigned T_GAP    = LCD_T_GAP_DEF,
    parameter int unsigned POLL_EN  = LCD_POLL_EN_DEF,
    parameter int unsigned POLL_MAX = LCD_POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_rw,
    input  logic [7:0] req_data,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       dir,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data
);

    lcd_state_e           state_q, state_d;
    logic [LCD_CNT_W-1:0] cnt_q, cnt_d;
    logic [LCD_CNT_W-1:0] polls_q, polls_d;
    logic                 rw_q, rw_d;
    logic                 poll_q, poll_d;
    logic [7:0]           rd_q, rd_d;
    logic                 lcd_rs_q, lcd_rs_d;
    logic                 lcd_rw_q, lcd_rw_d;
    logic                 lcd_e_q, lcd_e_d;
    logic                 dir_q, dir_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [7:0]           resp_data_q, resp_data_d;
    logic                 start_poll;
    logic                 finish;
    logic                 finish_err;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = lcd_rw_q;
    assign lcd_e      = lcd_e_q;
    assign dir        = dir_q;
    assign wr_data    = wr_data_q;

    // Next-state and registered-output logic; all pin values are computed
    // for the state being entered so they change together with the state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        polls_d      = polls_q;
        rw_d         = rw_q;
        poll_d       = poll_q;
        rd_d         = rd_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_rw_d     = lcd_rw_q;
        lcd_e_d      = lcd_e_q;
        dir_d        = dir_q;
        wr_data_d    = wr_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = resp_data_q;
        start_poll   = 1'b0;
        finish       = 1'b0;
        finish_err   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                lcd_e_d = 1'b0;
                if (req_valid) begin
                    state_d   = ST_SETUP;
                    cnt_d     = lcd_load(T_AS);
                    rw_d      = req_rw;
                    poll_d    = 1'b0;
                    polls_d   = '0;
                    lcd_rs_d  = req_rs;
                    lcd_rw_d  = req_rw;
                    dir_d     = req_rw;
                    wr_data_d = req_data;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = lcd_load(T_PW);
                    lcd_e_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = lcd_load(T_H);
                    lcd_e_d = 1'b0;
                    if (rw_q) begin
                        rd_d = rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d  = ST_GAP;
                    cnt_d    = lcd_load(T_GAP);
                    lcd_rw_d = 1'b0;
                    dir_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (poll_q) begin
                        if (!rd_q[7]) begin
                            finish = 1'b1;
                        end else if (32'(polls_q) >= POLL_MAX) begin
                            finish     = 1'b1;
                            finish_err = 1'b1;
                        end else begin
                            start_poll = 1'b1;
                        end
                    end else if (!rw_q && (POLL_EN != 0)) begin
                        start_poll = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Busy-flag poll: instruction-register read reusing the normal cycle.
        if (start_poll) begin
            state_d  = ST_SETUP;
            cnt_d    = lcd_load(T_AS);
            poll_d   = 1'b1;
            polls_d  = polls_q + 1'b1;
            rw_d     = 1'b1;
            lcd_rs_d = 1'b0;
            lcd_rw_d = 1'b1;
            dir_d    = 1'b1;
        end

        if (finish) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = finish_err;
            resp_data_d  = (rw_q && !poll_q) ? rd_q : 8'h00;
        end
    end

    // State, counter and output registers; reset forces IDLE with pins low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            polls_q      <= '0;
            rw_q         <= 1'b0;
            poll_q       <= 1'b0;
            rd_q         <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_rw_q     <= 1'b0;
            lcd_e_q      <= 1'b0;
            dir_q        <= 1'b0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            polls_q      <= polls_d;
            rw_q         <= rw_d;
            poll_q       <= poll_d;
            rd_q         <= rd_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_rw_q     <= lcd_rw_d;
            lcd_e_q      <= lcd_e_d;
            dir_q        <= dir_d;
            wr_data_q    <= wr_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_lcd_bus_controller.sv
// Directed bench for lcd_bus_controller: instance A uses default timing with
// polling off, instance B uses short/zero timing with polling and POLL_MAX=4.
module tb_lcd_bus_controller;

    logic       clk;
    logic       rst_n;
    logic       req_valid_a, req_valid_b;
    logic       req_rs, req_rw;
    logic [7:0] req_data;
    logic [7:0] rd_data;

    logic       ready_a, rv_a, rerr_a, rs_a, rw_a, e_a, dir_a;
    logic [7:0] rdata_a, wd_a;
    logic       ready_b, rv_b, rerr_b, rs_b, rw_b, e_b, dir_b;
    logic [7:0] rdata_b, wd_b;

    logic       sel;
    logic       s_ready, s_rv, s_rerr, s_rs, s_rw, s_e, s_dir;
    logic [7:0] s_rdata, s_wd;

    int checks;
    int failures;

    lcd_bus_controller #(
        .POLL_EN (0)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_a),
        .req_ready  (ready_a),
        .req_rs     (req_rs),
        .req_rw     (req_rw),
        .req_data   (req_data),
        .resp_valid (rv_a),
        .resp_data  (rdata_a),
        .resp_err   (rerr_a),
        .lcd_rs     (rs_a),
        .lcd_rw     (rw_a),
        .lcd_e      (e_a),
        .dir        (dir_a),
        .wr_data    (wd_a),
        .rd_data    (rd_data)
    );

    lcd_bus_controller #(
        .T_AS     (0),
        .T_PW     (4),
        .T_H      (0),
        .T_GAP    (3),
        .POLL_EN  (1),
        .POLL_MAX (4)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_b),
        .req_ready  (ready_b),
        .req_rs     (req_rs),
        .req_rw     (req_rw),
        .req_data   (req_data),
        .resp_valid (rv_b),
        .resp_data  (rdata_b),
        .resp_err   (rerr_b),
        .lcd_rs     (rs_b),
        .lcd_rw     (rw_b),
        .lcd_e      (e_b),
        .dir        (dir_b),
        .wr_data    (wd_b),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_ready = sel ? ready_b : ready_a;
        s_rv    = sel ? rv_b    : rv_a;
        s_rerr  = sel ? rerr_b  : rerr_a;
        s_rs    = sel ? rs_b    : rs_a;
        s_rw    = sel ? rw_b    : rw_a;
        s_e     = sel ? e_b     : e_a;
        s_dir   = sel ? dir_b   : dir_a;
        s_rdata = sel ? rdata_b : rdata_a;
        s_wd    = sel ? wd_b    : wd_a;
    end

    typedef struct {
        bit         sel;
        bit         rs;
        bit         rw;
        logic [7:0] data;
        logic [7:0] rdval;
        int         busy;
        int         exp_rise;
        int         exp_pulses;
        int         exp_plen;
        int         exp_lat;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 500 && !s_ready; i++) @(negedge clk);
        check(name, 32'(s_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k, rise, pulses, rv_cnt, rv_k, cur_len, plen_bad, since_fall, th, hold_end;
        int viol_stab, viol_dir, viol_poll, viol_ready;
        logic e_prev, dir_prev, exp_idle_rs;
        logic [7:0] got_rdata;
        logic got_err;
        rise = -1; pulses = 0; rv_cnt = 0; rv_k = -1; cur_len = 0; plen_bad = 0;
        since_fall = 1000; viol_stab = 0; viol_dir = 0; viol_poll = 0; viol_ready = 0;
        got_rdata = 8'hxx; got_err = 1'bx;
        th = v.sel ? 1 : 2;
        hold_end = v.exp_rise + v.exp_plen + th - 1;
        sel = v.sel;
        @(negedge clk);
        wait_ready($sformatf("v%0d_ready_idle", idx));
        req_rs = v.rs; req_rw = v.rw; req_data = v.data;
        rd_data = (v.sel && !v.rw) ? 8'h00 : v.rdval;
        if (v.sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        e_prev = s_e;
        dir_prev = s_dir;
        @(posedge clk);
        for (k = 0; k <= v.exp_lat + 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid_a = 1'b0;
                req_valid_b = 1'b0;
                req_data = 8'h00;
                req_rs = ~v.rs;
            end
            if (s_e && !e_prev) begin
                pulses++;
                if (pulses == 1) rise = k;
                cur_len = 0;
            end
            if (s_e) cur_len++;
            if (!s_e && e_prev) begin
                if (cur_len != v.exp_plen) plen_bad++;
                since_fall = 0;
            end else begin
                since_fall++;
            end
            if (s_dir != dir_prev && (s_e || e_prev || since_fall < th)) viol_dir++;
            if (k <= hold_end &&
                (s_rs != v.rs || s_rw != v.rw || s_dir != v.rw || s_wd != v.data)) viol_stab++;
            if (s_e && pulses > 1 && (s_rs != 1'b0 || s_rw != 1'b1 || s_dir != 1'b1)) viol_poll++;
            if (k < v.exp_lat && s_ready) viol_ready++;
            if (s_rv) begin
                rv_cnt++;
                rv_k = k;
                got_rdata = s_rdata;
                got_err = s_rerr;
            end
            if (v.sel && !v.rw) rd_data = (pulses <= v.busy + 1) ? 8'h80 : 8'h00;
            e_prev = s_e;
            dir_prev = s_dir;
        end
        exp_idle_rs = (v.exp_pulses > 1) ? 1'b0 : v.rs;
        check($sformatf("v%0d_e_rise", idx), 32'(rise), 32'(v.exp_rise));
        check($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
        check($sformatf("v%0d_plen_bad", idx), 32'(plen_bad), 32'd0);
        check($sformatf("v%0d_resp_cnt", idx), 32'(rv_cnt), 32'd1);
        check($sformatf("v%0d_resp_lat", idx), 32'(rv_k), 32'(v.exp_lat));
        check($sformatf("v%0d_resp_data", idx), 32'(got_rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d_resp_err", idx), 32'(got_err), 32'(v.exp_err));
        check($sformatf("v%0d_stable", idx), 32'(viol_stab), 32'd0);
        check($sformatf("v%0d_dir_vs_e", idx), 32'(viol_dir), 32'd0);
        check($sformatf("v%0d_poll_pins", idx), 32'(viol_poll), 32'd0);
        check($sformatf("v%0d_busy_ready", idx), 32'(viol_ready), 32'd0);
        check($sformatf("v%0d_idle_pins", idx),
              {28'd0, s_ready, s_e, s_dir, s_rw}, {28'd0, 4'b1000});
        check($sformatf("v%0d_idle_rs", idx), 32'(s_rs), 32'(exp_idle_rs));
    endtask

    initial begin
        int k, rv_cnt, acc2, pulses_before, pulses, viol_dir;
        logic e_prev, dir_prev;
        clk = 1'b0;
        rst_n = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_rs = 1'b0; req_rw = 1'b0; req_data = 8'h00; rd_data = 8'h00;
        sel = 1'b0;
        checks = 0;
        failures = 0;

        //                 sel rs rw data   rdval  busy rise pls plen lat  rdata  err
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h41, 8'h00,   0,  6,  1,  45, 103, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h5A,   0,  6,  1,  45, 103, 8'h5A, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h38, 8'h00,   0,  6,  1,  45, 103, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hA5,   0,  6,  1,  45, 103, 8'hA5, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h41, 8'h00,   3,  1,  5,   4,  45, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h42, 8'h00,   0,  1,  2,   4,  18, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 100,  1,  5,   4,  45, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hC3,   0,  1,  1,   4,   9, 8'hC3, 1'b0};

        #1;
        check("rst_outputs_a", {rv_a, rerr_a, rs_a, rw_a, e_a, dir_a, rdata_a, wd_a}, 32'd0);
        check("rst_outputs_b", {rv_b, rerr_b, rs_b, rw_b, e_b, dir_b, rdata_b, wd_b}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_a", 32'(ready_a), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset during the E pulse: E drops at once, no response follows.
        sel = 1'b0;
        @(negedge clk);
        wait_ready("rstmid_ready");
        req_rs = 1'b1; req_rw = 1'b0; req_data = 8'hFF; req_valid_a = 1'b1;
        @(posedge clk);
        for (k = 0; k < 25; k++) begin
            @(negedge clk);
            req_valid_a = 1'b0;
        end
        check("rstmid_e_high", 32'(s_e), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_e_drop", 32'(s_e), 32'd0);
        check("rstmid_pins", {s_rs, s_rw, s_dir, s_rv, s_wd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready", 32'(s_ready), 32'd1);
        rv_cnt = 0;
        for (k = 0; k < 150; k++) begin
            @(negedge clk);
            if (s_rv) rv_cnt++;
        end
        check("rstmid_no_resp", 32'(rv_cnt), 32'd0);

        // req_valid held high: second request waits for the end of GAP.
        sel = 1'b0;
        wait_ready("b2b_ready");
        req_rs = 1'b1; req_rw = 1'b0; req_data = 8'h11; req_valid_a = 1'b1;
        e_prev = s_e; dir_prev = s_dir;
        @(posedge clk);
        acc2 = -1; pulses = 0; pulses_before = -1; rv_cnt = 0; viol_dir = 0;
        for (k = 0; k < 220; k++) begin
            @(negedge clk);
            if (k == acc2) req_valid_a = 1'b0;
            if (s_e && !e_prev) pulses++;
            if (s_dir != dir_prev && (s_e || e_prev)) viol_dir++;
            if (s_rv) rv_cnt++;
            if (acc2 < 0 && s_ready && req_valid_a) begin
                acc2 = k + 1;
                pulses_before = pulses;
            end
            e_prev = s_e;
            dir_prev = s_dir;
        end
        check("b2b_second_accept", 32'(acc2), 32'd104);
        check("b2b_not_queued", 32'(pulses_before), 32'd1);
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_resps", 32'(rv_cnt), 32'd2);
        check("b2b_dir_vs_e", 32'(viol_dir), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
